// File: rtl/seg7_scan_mux.sv
// Two-digit multiplexed 7-segment driver: per-frame input snapshot, hex decode,
// anode scanning with a blanking gap at the start of each digit slot.
module seg7_scan_mux #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] din_lo,
    input  logic [3:0] din_hi,
    input  logic [1:0] dp_en,
    input  logic       blank_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       upd_pulse
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [1:0] AN_OFF  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             digit;
    logic             digit_nxt;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [7:0]       shadow;
    logic [7:0]       shadow_nxt;
    logic [7:0]       din_cat;
    logic             slot_end;
    logic             frame_end;
    logic             drive;
    logic [3:0]       nib;
    logic [6:0]       seg_hi;
    logic             dp_hi;
    logic [1:0]       an_hi;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;
    logic [1:0]       an_nxt;
    logic             upd_nxt;

    // Hex decode, active-high, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h00;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            digit     <= 1'b0;
            state     <= ST_BLANK;
            shadow    <= 8'h00;
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            an        <= AN_OFF;
            upd_pulse <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            digit     <= digit_nxt;
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            seg       <= seg_nxt;
            dp        <= dp_nxt;
            an        <= an_nxt;
            upd_pulse <= upd_nxt;
        end
    end

    // Next-state and next-pin logic; pins reflect the current cycle one clock later
    always_comb begin
        cnt_inc    = cnt + CNT_W'(1);
        cnt_nxt    = cnt_inc;
        digit_nxt  = digit;
        state_nxt  = state;
        shadow_nxt = shadow;
        din_cat    = {din_hi, din_lo};
        slot_end   = (cnt == CNT_LAST);
        frame_end  = slot_end && digit;
        upd_nxt    = 1'b0;

        if (slot_end) begin
            cnt_nxt   = '0;
            digit_nxt = ~digit;
        end

        case (state)
            ST_BLANK: if (!slot_end && (cnt_inc == BLANK_END)) state_nxt = ST_DRIVE;
            ST_DRIVE: if (slot_end) state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase

        if (frame_end) begin
            shadow_nxt = din_cat;
            upd_nxt    = (din_cat != shadow);
        end

        drive  = (state == ST_DRIVE) && !blank_en;
        nib    = digit ? shadow[7:4] : shadow[3:0];
        seg_hi = drive ? hex_decode(nib) : 7'h00;
        dp_hi  = drive && dp_en[digit];
        an_hi  = drive ? (digit ? 2'b10 : 2'b01) : 2'b00;

        seg_nxt = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_nxt  = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
        an_nxt  = AN_ACTIVE_LOW ? ~an_hi : an_hi;
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: stimulus pushes expected pins per clock,
// a monitor pops and compares after each edge; directed spot checks alongside.
module tb_seg7_scan_mux;

    localparam int unsigned CLK_DIV   = 8;
    localparam int unsigned BLANK_CYC = 2;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       upd;
    } pins_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] din_lo;
    logic [3:0] din_hi;
    logic [1:0] dp_en;
    logic       blank_en;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic       upd_pulse;

    int total = 0;
    int bad = 0;
    int upd_seen = 0;
    int base;
    pins_t q[$];

    int         m_cnt;
    logic       m_digit;
    logic [7:0] m_shadow;

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_mux #(
        .CLK_DIV(CLK_DIV),
        .BLANK_CYC(BLANK_CYC),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .din_lo(din_lo),
        .din_hi(din_hi),
        .dp_en(dp_en),
        .blank_en(blank_en),
        .seg(seg),
        .dp(dp),
        .an(an),
        .upd_pulse(upd_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected pins after the coming edge, from the inputs now applied
    task automatic model_push();
        pins_t      e;
        logic       drv;
        logic [3:0] nib;
        drv   = (m_cnt >= BLANK_CYC) && !blank_en;
        nib   = m_digit ? m_shadow[7:4] : m_shadow[3:0];
        e.an  = drv ? (m_digit ? 2'b01 : 2'b10) : 2'b11;
        e.seg = drv ? ~dec_tab[nib] : 7'h7F;
        e.dp  = !(drv && dp_en[m_digit]);
        e.upd = (m_cnt == CLK_DIV - 1) && m_digit && ({din_hi, din_lo} != m_shadow);
        q.push_back(e);
        if (m_cnt == CLK_DIV - 1) begin
            if (m_digit) m_shadow = {din_hi, din_lo};
            m_digit = ~m_digit;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic tick();
        model_push();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_pins(input string nm);
        chk({nm, "_an"}, 32'(an), 32'h3);
        chk({nm, "_seg"}, 32'(seg), 32'h7F);
        chk({nm, "_dp"}, 32'(dp), 32'h1);
        chk({nm, "_upd"}, 32'(upd_pulse), 32'h0);
    endtask

    // Async assert with no clock edge before the first check, then release on a negedge
    task automatic do_reset(input string nm);
        q.delete();
        reset_n = 1'b0;
        #1;
        chk_reset_pins({nm, "_async"});
        repeat (3) @(negedge clk);
        chk_reset_pins({nm, "_held"});
        reset_n  = 1'b1;
        m_cnt    = 0;
        m_digit  = 1'b0;
        m_shadow = 8'h00;
    endtask

    always @(posedge clk) begin
        pins_t e;
        #2;
        if (reset_n === 1'b1 && upd_pulse === 1'b1) upd_seen++;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("pins{an,seg,dp,upd}", 32'({an, seg, dp, upd_pulse}), 32'(e));
        end
    end

    initial begin
        logic [6:0] exp_seg;
        din_hi   = 4'h0;
        din_lo   = 4'h0;
        dp_en    = 2'b00;
        blank_en = 1'b0;

        do_reset("rst0");
        din_hi = 4'hC;
        din_lo = 4'h3;
        ticks(3);
        chk("f1_an", 32'(an), 32'h2);
        chk("f1_seg_zero", 32'(seg), 32'h40);
        ticks(13);
        chk("snap_upd", 32'(upd_pulse), 32'h1);
        ticks(3);
        chk("f2_d0_an", 32'(an), 32'h2);
        chk("f2_d0_seg", 32'(seg), 32'h30);
        chk("f2_upd_low", 32'(upd_pulse), 32'h0);
        tick();
        din_lo = 4'h7;
        ticks(7);
        chk("f2_d1_an", 32'(an), 32'h1);
        chk("f2_d1_seg", 32'(seg), 32'h46);
        ticks(5);
        chk("mid_upd", 32'(upd_pulse), 32'h1);
        ticks(3);
        chk("f3_d0_seg", 32'(seg), 32'h78);
        ticks(13);
        chk("hold_no_upd", 32'(upd_pulse), 32'h0);

        ticks(4);
        blank_en = 1'b1;
        tick();
        chk("blank_an", 32'(an), 32'h3);
        chk("blank_seg", 32'(seg), 32'h7F);
        chk("blank_dp", 32'(dp), 32'h1);
        blank_en = 1'b0;
        tick();
        chk("unblank_an", 32'(an), 32'h2);
        chk("unblank_seg", 32'(seg), 32'h78);
        blank_en = 1'b1;
        din_lo   = 4'h5;
        ticks(10);
        chk("blank_snap_upd", 32'(upd_pulse), 32'h1);
        chk("blank_snap_an", 32'(an), 32'h3);
        blank_en = 1'b0;

        dp_en = 2'b10;
        ticks(11);
        chk("dp_d1_an", 32'(an), 32'h1);
        chk("dp_d1_dp", 32'(dp), 32'h0);
        chk("dp_d1_seg", 32'(seg), 32'h46);
        ticks(8);
        chk("dp_d0_an", 32'(an), 32'h2);
        chk("dp_d0_dp", 32'(dp), 32'h1);
        chk("dp_d0_seg", 32'(seg), 32'h12);

        do_reset("rst1");
        ticks(3);
        chk("post_rst_d0_an", 32'(an), 32'h2);
        chk("post_rst_d0_seg", 32'(seg), 32'h40);
        ticks(8);
        chk("post_rst_d1_an", 32'(an), 32'h1);
        chk("post_rst_d1_seg", 32'(seg), 32'h40);
        chk("post_rst_d1_dp", 32'(dp), 32'h0);
        ticks(5);
        chk("post_rst_upd", 32'(upd_pulse), 32'h1);

        dp_en = 2'b00;
        base  = upd_seen;
        for (int v = 0; v <= 16; v++) begin
            din_lo = (v < 16) ? 4'(v) : 4'hF;
            ticks(3);
            if (v > 0) begin
                exp_seg = ~dec_tab[v-1];
                chk($sformatf("sweep_seg_%0d", v - 1), 32'(seg), 32'(exp_seg));
            end
            ticks(13);
        end
        chk("sweep_upd_count", 32'(upd_seen - base), 32'd16);

        ticks(2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Two-digit multiplexed 7-segment display driver that sits directly downstream of the dual nibble counter stage. It consumes the up-count and down-count nibbles and snapshots them once per display frame, so both digits always come from the same frame. It decodes each nibble to hex segment patterns and time-multiplexes the two digit anodes, with a programmable blanking gap at the start of each digit slot to prevent ghosting. All pin outputs are registered.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot; legal range is CLK_DIV >= BLANK_CYC+2.
BLANK_CYC, 16, cycles at the start of each slot during which the anodes are held inactive; BLANK_CYC >= 1.
SEG_ACTIVE_LOW, 1, 1 means seg and dp pins are active-low; 0 means active-high.
AN_ACTIVE_LOW, 1, 1 means an pins are active-low; 0 means active-high.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset_n  input  1  asynchronous active-low reset.
din_lo  input  4  nibble shown on digit 0 (up-count).
din_hi  input  4  nibble shown on digit 1 (down-count).
dp_en  input  2  bit i enables the decimal point while digit i is driven.
blank_en  input  1  synchronous force-blank; all anodes inactive while high.
seg  output  7  segment pins, bit order {g,f,e,d,c,b,a}.
dp  output  1  decimal point pin.
an  output  2  anode select; bit i selects digit i.
upd_pulse  output  1  one-cycle strobe when a frame snapshot differs from the previous snapshot.

Behaviour:
- Reset (async, reset_n=0):
  - prescaler cnt=0, digit=0, state=BLANK, shadow=8'h00.
  - an=all inactive, seg=all off, dp=off, upd_pulse=0.
  - With default polarities this is an=2'b11, seg=7'h7F, dp=1.
- Prescaler: cnt runs 0..CLK_DIV-1 and wraps to 0.
  - At cnt==CLK_DIV-1, digit toggles on the same edge.
  - The prescaler runs regardless of blank_en.
- State machine per slot:
  - BLANK while cnt < BLANK_CYC; DRIVE while cnt >= BLANK_CYC.
  - BLANK->DRIVE when cnt reaches BLANK_CYC.
  - DRIVE->BLANK when cnt wraps to 0.
- Output latency: pins at cycle t+1 reflect (state, digit, shadow, dp_en, blank_en) sampled at cycle t. Latency is exactly 1 clk.
- Anodes:
  - an[digit] is active only when state==DRIVE and blank_en==0.
  - Otherwise every anode is inactive.
  - Never more than one anode active at once.
- Segments:
  - seg = decode(shadow nibble for the current digit) when the anode is active; otherwise all off.
  - dp is on only when the anode is active and dp_en[digit]==1.
- Decode, active-high, gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - When SEG_ACTIVE_LOW=1, seg and dp pins are inverted.
- Snapshot:
  - On the edge where cnt==CLK_DIV-1 and digit==1 (frame end), shadow <= {din_hi,din_lo}.
  - On that same edge, upd_pulse <= ({din_hi,din_lo} != old shadow). Otherwise upd_pulse <= 0.
  - upd_pulse is therefore high for exactly one cycle, aligned with the first cycle of the new frame.
  - Input changes mid-frame have no visible effect until the next frame end.
- blank_en:
  - Takes effect on the pins one cycle after assertion.
  - Does not reset cnt, digit or shadow; on deassertion, display resumes in the current slot phase.
  - Snapshot and upd_pulse continue while blanked.
- Reset mid-operation: pins go to reset values immediately (asynchronously). After release, the first slot begins at cnt=0, digit=0.
- Inputs are assumed synchronous to clk; no CDC logic is inside the block.

Test Plan:
(Sim parameters: CLK_DIV=8, BLANK_CYC=2, default polarities.)
- Reset: hold reset_n=0 for 3 cycles -> an=2'b11, seg=7'h7F, dp=1, upd_pulse=0. After release, an stays 2'b11 through cycle 2, then an=2'b10, seg=7'h40 (shadow 0) for cycles 3..8.
- Snapshot: din_hi=4'hC, din_lo=4'h3 stable before cycle 15 -> upd_pulse high for exactly the 1 cycle after edge 16. In frame 2, digit 0 drives an=2'b10 with seg=7'h30; digit 1 drives an=2'b01 with seg=7'h46.
- Mid-frame change: change din_lo 3->7 at cnt=4 of digit 0 -> seg stays 7'h30 for the rest of the frame, switches to 7'h78 in the next frame, and upd_pulse fires once. Holding 7 for another frame produces no further pulse.
- blank_en: assert during DRIVE -> an=2'b11, seg=7'h7F, dp=1 on the next cycle. Deassert at cnt=5 -> the anode returns on the next cycle with the correct digit, and cnt is undisturbed.
- dp and async reset: dp_en=2'b10 -> dp=0 only during digit-1 DRIVE cycles. Drop reset_n mid-DRIVE -> pins go to reset values without waiting for a clk edge; shadow reads back 0 (display shows 0,0) in the first frame after release.
- Decode sweep: step din_lo through 0..F, one value per frame -> digit-0 seg equals the bitwise inverse of the decode table for every value, and upd_pulse fires 16 times.
